// File: rtl/imm_patcher.sv
// rtl/imm_patcher.sv - scatter a signed immediate into an I/S/B/J instruction word via read-modify-write
module imm_patcher #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_imm,
    input  logic [1:0]        req_imm_src,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_err,
    output logic [31:0]       rsp_instr,
    output logic [CNT_W-1:0]  patch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RSP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_imm;
    logic [1:0]         r_src;
    logic [31:0]        r_word;
    logic [1:0]         r_err;
    logic [CNT_W-1:0]   r_count;

    logic [31:0]        w_word;
    logic               w_ovf;
    logic               w_mis;
    logic [1:0]         w_err;

    // Range check: every bit above the field's sign bit must copy the sign.
    always_comb begin
        w_word = mem_rdata;
        w_ovf  = 1'b0;
        case (r_src)
            2'b00: begin
                w_word[31:20] = r_imm[11:0];
                w_ovf = !((&r_imm[31:11]) || (r_imm[31:11] == '0));
            end
            2'b01: begin
                w_word[31:25] = r_imm[11:5];
                w_word[11:7]  = r_imm[4:0];
                w_ovf = !((&r_imm[31:11]) || (r_imm[31:11] == '0));
            end
            2'b10: begin
                w_word[31]    = r_imm[12];
                w_word[30:25] = r_imm[10:5];
                w_word[11:8]  = r_imm[4:1];
                w_word[7]     = r_imm[11];
                w_ovf = !((&r_imm[31:12]) || (r_imm[31:12] == '0));
            end
            default: begin
                w_word[31]    = r_imm[20];
                w_word[30:21] = r_imm[10:1];
                w_word[20]    = r_imm[11];
                w_word[19:12] = r_imm[19:12];
                w_ovf = !((&r_imm[31:20]) || (r_imm[31:20] == '0));
            end
        endcase
        w_mis = r_src[1] & r_imm[0];
        w_err = {w_mis, w_ovf};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_RD;
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = (w_err != 2'b00) ? S_RSP : S_WR;
            S_WR:    w_next = S_RSP;
            S_RSP:   if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_imm   <= '0;
            r_src   <= '0;
            r_word  <= '0;
            r_err   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_addr <= req_addr;
                r_imm  <= req_imm;
                r_src  <= req_imm_src;
            end
            // On error the original word is kept so the requester sees what is in memory.
            if (r_state == S_CAP) begin
                r_err  <= w_err;
                r_word <= (w_err == 2'b00) ? w_word : mem_rdata;
            end
            if (r_state == S_WR && r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign mem_rd_en   = (r_state == S_RD);
    assign mem_wr_en   = (r_state == S_WR);
    assign rsp_valid   = (r_state == S_RSP);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_word;
    assign rsp_err     = r_err;
    assign rsp_instr   = r_word;
    assign patch_count = r_count;

endmodule

// File: tb/tb_imm_patcher.sv
// tb/tb_imm_patcher.sv - vector table, corner sequences and random round-trip checks for imm_patcher
module tb_imm_patcher;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_imm;
    logic [1:0]        req_imm_src;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_err;
    logic [31:0]       rsp_instr;
    logic [CNT_W-1:0]  patch_count;

    always #5 clk = ~clk;

    imm_patcher #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_imm(req_imm), .req_imm_src(req_imm_src),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
        .rsp_instr(rsp_instr), .patch_count(patch_count)
    );

    // Instruction memory: synchronous read, plus a preload port for the bench.
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [31:0]       pl_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] place(input logic [31:0] w, input int hi, input int lo,
                                          input logic [31:0] v);
        for (int k = lo; k <= hi; k++) w[k] = v[k-lo];
        return w;
    endfunction

    function automatic logic [31:0] model_encode(input logic [31:0] orig, input logic [31:0] imm,
                                                 input logic [1:0] src);
        logic [31:0] w;
        w = orig;
        case (src)
            2'd0: w = place(w, 31, 20, imm);
            2'd1: begin w = place(w, 31, 25, imm >> 5); w = place(w, 11, 7, imm); end
            2'd2: begin
                w = place(w, 31, 31, imm >> 12); w = place(w, 7, 7, imm >> 11);
                w = place(w, 30, 25, imm >> 5);  w = place(w, 11, 8, imm >> 1);
            end
            default: begin
                w = place(w, 31, 31, imm >> 20); w = place(w, 19, 12, imm >> 12);
                w = place(w, 20, 20, imm >> 11); w = place(w, 30, 21, imm >> 1);
            end
        endcase
        return w;
    endfunction

    function automatic logic [1:0] model_err(input logic [31:0] imm, input logic [1:0] src);
        int     bits;
        longint s, lim;
        logic   ovf;
        bits = (src == 2'd2) ? 13 : (src == 2'd3) ? 21 : 12;
        s    = longint'($signed(imm));
        lim  = longint'(1) << (bits - 1);
        ovf  = (s < -lim) || (s > lim - 1);
        return {src[1] & imm[0], ovf};
    endfunction

    function automatic logic [31:0] core_decode(input logic [31:0] i, input logic [1:0] src);
        case (src)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input logic [1:0] src);
        case (src)
            2'd0:    return 32'hFFF0_0000;
            2'd3:    return 32'hFFFF_F000;
            default: return 32'hFE00_0F80;
        endcase
    endfunction

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk); pl_en = 1'b0;
    endtask

    task automatic transact(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] orig,
                            input logic [31:0] imm, input logic [1:0] src, input int hold,
                            input logic [31:0] exp_instr, input logic [1:0] exp_err,
                            output logic [31:0] got);
        int cyc, rd_n, rd_at, wr_n, wr_at;
        logic [ADDR_W-1:0] rd_addr, wr_addr;
        logic [31:0] wr_data;
        preload(a, orig);
        req_valid = 1'b1; req_addr = a; req_imm = imm; req_imm_src = src;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = ~a; req_imm = ~imm; req_imm_src = ~src;
        cyc = 0; rd_n = 0; rd_at = 0; wr_n = 0; wr_at = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        while (!rsp_valid && cyc < 20) begin
            @(negedge clk); cyc++;
            if (mem_rd_en) begin rd_n++; rd_at = cyc; rd_addr = mem_addr; end
            if (mem_wr_en) begin wr_n++; wr_at = cyc; wr_addr = mem_addr; wr_data = mem_wdata; end
        end
        chk({tag, " latency"}, cyc, (exp_err == 2'b00) ? 4 : 3);
        chk({tag, " rd_count"}, rd_n, 1);
        chk({tag, " rd_cycle"}, rd_at, 1);
        chk({tag, " rd_addr"}, 32'(rd_addr), 32'(a));
        chk({tag, " wr_count"}, wr_n, (exp_err == 2'b00) ? 1 : 0);
        if (exp_err == 2'b00) begin
            chk({tag, " wr_cycle"}, wr_at, 3);
            chk({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
            chk({tag, " wr_data"}, wr_data, exp_instr);
        end
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rsp_instr"}, rsp_instr, exp_instr);
        got = rsp_instr;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold rsp_valid"}, 32'(rsp_valid), 1);
            chk({tag, " hold req_ready"}, 32'(req_ready), 0);
            chk({tag, " hold rsp_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, " hold rsp_instr"}, rsp_instr, exp_instr);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " idle req_ready"}, 32'(req_ready), 1);
        chk({tag, " idle rsp_valid"}, 32'(rsp_valid), 0);
        if (exp_err == 2'b00 && exp_count < int'(CNT_MAX)) exp_count++;
        chk({tag, " patch_count"}, 32'(patch_count), exp_count);
        chk({tag, " mem word"}, mem[a], (exp_err == 2'b00) ? exp_instr : orig);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       orig;
        logic [31:0]       imm;
        logic [1:0]        src;
        logic [31:0]       exp_instr;
        logic [1:0]        exp_err;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, r, imm, orig, exp_instr;
        logic [1:0]  src, exp_err;
        logic [ADDR_W-1:0] a;
        int k;

        tbl[0]  = '{10'd5,  32'h0000_0013, 32'hFFFF_FFFF, 2'd0, 32'hFFF0_0013, 2'b00};
        tbl[1]  = '{10'd6,  32'h0000_2023, 32'h0000_07E5, 2'd1, 32'h7E00_22A3, 2'b00};
        tbl[2]  = '{10'd7,  32'h0000_0063, 32'hFFFF_FFFC, 2'd2, 32'hFE00_0EE3, 2'b00};
        tbl[3]  = '{10'd8,  32'h0000_006F, 32'h0000_0800, 2'd3, 32'h0010_006F, 2'b00};
        tbl[4]  = '{10'd9,  32'h0000_0013, 32'd2048,      2'd0, 32'h0000_0013, 2'b01};
        tbl[5]  = '{10'd10, 32'h0000_0063, 32'd3,         2'd2, 32'h0000_0063, 2'b10};
        tbl[6]  = '{10'd11, 32'h0000_0063, 32'd4097,      2'd2, 32'h0000_0063, 2'b11};
        tbl[7]  = '{10'd12, 32'h0000_0013, 32'd2047,      2'd0, 32'h7FF0_0013, 2'b00};
        tbl[8]  = '{10'd13, 32'h0000_0013, 32'hFFFF_F800, 2'd0, 32'h8000_0013, 2'b00};
        tbl[9]  = '{10'd14, 32'h0000_006F, 32'h000F_FFFE, 2'd3, 32'h7FFF_F06F, 2'b00};
        tbl[10] = '{10'd15, 32'h0000_006F, 32'h0010_0000, 2'd3, 32'h0000_006F, 2'b01};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_imm = '0; req_imm_src = '0;
        rsp_ready = 1'b0;
        #12;
        chk("reset req_ready", 32'(req_ready), 1);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset mem_rd_en", 32'(mem_rd_en), 0);
        chk("reset mem_wr_en", 32'(mem_wr_en), 0);
        chk("reset rsp_err", 32'(rsp_err), 0);
        chk("reset rsp_instr", rsp_instr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset mem_addr", 32'(mem_addr), 0);
        chk("reset patch_count", 32'(patch_count), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            transact($sformatf("vec%0d", i), tbl[i].addr, tbl[i].orig, tbl[i].imm, tbl[i].src,
                     (i == 1) ? 5 : 0, tbl[i].exp_instr, tbl[i].exp_err, got);
        end

        // Reset while the write strobe is up: no write, no response.
        preload(10'd20, 32'h0000_0013);
        req_valid = 1'b1; req_addr = 10'd20; req_imm = 32'd5; req_imm_src = 2'd0;
        @(posedge clk); #1; req_valid = 1'b0;
        k = 0;
        while (!mem_wr_en && k < 20) begin @(negedge clk); k++; end
        chk("rstwr reached WR", 32'(mem_wr_en), 1);
        rst_n = 1'b0; #1;
        chk("rstwr mem_wr_en", 32'(mem_wr_en), 0);
        chk("rstwr req_ready", 32'(req_ready), 1);
        chk("rstwr rsp_valid", 32'(rsp_valid), 0);
        chk("rstwr patch_count", 32'(patch_count), 0);
        @(negedge clk); rst_n = 1'b1;
        exp_count = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rstwr no rsp", 32'(rsp_valid), 0);
            chk("rstwr no wr", 32'(mem_wr_en), 0);
        end
        chk("rstwr mem intact", mem[20], 32'h0000_0013);

        // Drive the counter to saturation, then confirm an error leaves it there.
        for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
            transact($sformatf("sat%0d", i), 10'd30, 32'h0000_0013, 32'(i), 2'd0, 0,
                     {12'(i), 20'h00013}, 2'b00, got);
        end
        chk("sat at all-ones", 32'(patch_count), 32'(CNT_MAX));
        transact("sat err", 10'd31, 32'h0000_0063, 32'd1, 2'd2, 0, 32'h0000_0063, 2'b10, got);

        for (int i = 0; i < 40; i++) begin
            src  = 2'($urandom_range(0, 3));
            r    = $urandom;
            orig = $urandom;
            a    = ADDR_W'($urandom_range(100, (1 << ADDR_W) - 1));
            if ($urandom_range(0, 3) == 0) imm = r;
            else case (src)
                2'd0, 2'd1: imm = {{20{r[11]}}, r[11:0]};
                2'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            exp_err   = model_err(imm, src);
            exp_instr = (exp_err == 2'b00) ? model_encode(orig, imm, src) : orig;
            transact($sformatf("rnd%0d", i), a, orig, imm, src, $urandom_range(0, 2),
                     exp_instr, exp_err, got);
            if (exp_err == 2'b00) begin
                chk($sformatf("rnd%0d roundtrip", i), core_decode(got, src), imm);
                chk($sformatf("rnd%0d preserved", i), got & ~field_mask(src), orig & ~field_mask(src));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
